// File: rtl/sincos_pkg.sv
// Shared constants and types for the sin/cos Horner sequencer.
package sincos_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SQ      = 4'd1,
    ST_SIN_MUL = 4'd2,
    ST_SIN_ADD = 4'd3,
    ST_SIN_FIN = 4'd4,
    ST_COS_MUL = 4'd5,
    ST_COS_ADD = 4'd6,
    ST_FIN     = 4'd7,
    ST_ABORT   = 4'd8
  } state_e;

  typedef enum logic {
    FPU_MUL = 1'b0,
    FPU_ADD = 1'b1
  } fpu_op_e;

  // Taylor coefficients of sin(x)/x in powers of x^2: 1, -1/6, 1/120, ...
  function automatic logic [31:0] s_coef(input logic [2:0] k);
    case (k)
      3'd0:    s_coef = FP_ONE;
      3'd1:    s_coef = 32'hBE2A_AAAB;
      3'd2:    s_coef = 32'h3C08_8889;
      3'd3:    s_coef = 32'hB950_0D01;
      3'd4:    s_coef = 32'h3638_EF1D;
      default: s_coef = 32'hB2D7_322B;
    endcase
  endfunction

  // Taylor coefficients of cos(x) in powers of x^2: 1, -1/2, 1/24, ...
  function automatic logic [31:0] c_coef(input logic [2:0] k);
    case (k)
      3'd0:    c_coef = FP_ONE;
      3'd1:    c_coef = 32'hBF00_0000;
      3'd2:    c_coef = 32'h3D2A_AAAB;
      3'd3:    c_coef = 32'hBAB6_0B61;
      3'd4:    c_coef = 32'h37D0_0D01;
      3'd5:    c_coef = 32'hB493_F27E;
      default: c_coef = 32'h310F_76C7;
    endcase
  endfunction

endpackage

// File: rtl/sincos_seq.sv
// Drives a shared FP32 mul/add unit through Horner evaluation of sin and cos,
// one outstanding operation at a time, with an FPU-ack timeout abort.
module sincos_seq
  import sincos_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] opx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sine_result,
  output logic [31:0] cosine_result,
  output logic        fpu_req,
  output logic        fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_ack,
  input  logic [31:0] fpu_result
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state;
  fpu_op_e     op_r;
  logic [2:0]  idx;
  logic [15:0] to_cnt;
  logic [31:0] x_r;
  logic [31:0] x2_r;
  logic [31:0] acc_r;
  logic [31:0] sin_r;

  state_e      nxt_state;
  fpu_op_e     nxt_op;
  logic [2:0]  nxt_idx;
  logic [31:0] nxt_a;
  logic [31:0] nxt_b;

  assign fpu_op = op_r;

  // Operation issued at the end of the idle gap that follows each ack.
  always_comb begin
    nxt_state = state;
    nxt_op    = FPU_MUL;
    nxt_idx   = idx;
    nxt_a     = acc_r;
    nxt_b     = x2_r;
    case (state)
      ST_SQ: begin
        nxt_state = ST_SIN_MUL;
        nxt_idx   = 3'd4;
        nxt_a     = s_coef(3'd5);
      end
      ST_SIN_MUL: begin
        nxt_state = ST_SIN_ADD;
        nxt_op    = FPU_ADD;
        nxt_b     = s_coef(idx);
      end
      ST_SIN_ADD: begin
        if (idx == 3'd0) begin
          nxt_state = ST_SIN_FIN;
          nxt_b     = x_r;
        end else begin
          nxt_state = ST_SIN_MUL;
          nxt_idx   = idx - 3'd1;
        end
      end
      ST_SIN_FIN: begin
        nxt_state = ST_COS_MUL;
        nxt_idx   = 3'd5;
        nxt_a     = c_coef(3'd6);
      end
      ST_COS_MUL: begin
        nxt_state = ST_COS_ADD;
        nxt_op    = FPU_ADD;
        nxt_b     = c_coef(idx);
      end
      ST_COS_ADD: begin
        if (idx == 3'd0) begin
          nxt_state = ST_FIN;
        end else begin
          nxt_state = ST_COS_MUL;
          nxt_idx   = idx - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      op_r          <= FPU_MUL;
      idx           <= 3'd0;
      to_cnt        <= 16'd0;
      x_r           <= 32'd0;
      x2_r          <= 32'd0;
      acc_r         <= 32'd0;
      sin_r         <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      sine_result   <= 32'd0;
      cosine_result <= 32'd0;
      fpu_req       <= 1'b0;
      fpu_a         <= 32'd0;
      fpu_b         <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SQ;
            x_r     <= opx;
            op_r    <= FPU_MUL;
            fpu_a   <= opx;
            fpu_b   <= opx;
            fpu_req <= 1'b1;
            busy    <= 1'b1;
            to_cnt  <= 16'd0;
          end
        end
        ST_FIN, ST_ABORT: state <= ST_IDLE;
        default: begin
          if (fpu_req) begin
            if (fpu_ack) begin
              fpu_req <= 1'b0;
              to_cnt  <= 16'd0;
              case (state)
                ST_SQ:      x2_r  <= fpu_result;
                ST_SIN_FIN: sin_r <= fpu_result;
                default:    acc_r <= fpu_result;
              endcase
            end else if (to_cnt == TO_LAST) begin
              state         <= ST_ABORT;
              fpu_req       <= 1'b0;
              to_cnt        <= 16'd0;
              busy          <= 1'b0;
              done          <= 1'b1;
              err           <= 1'b1;
              sine_result   <= FP_QNAN;
              cosine_result <= FP_QNAN;
            end else begin
              to_cnt <= to_cnt + 16'd1;
            end
          end else if (nxt_state == ST_FIN) begin
            state         <= ST_FIN;
            busy          <= 1'b0;
            done          <= 1'b1;
            sine_result   <= sin_r;
            cosine_result <= acc_r;
          end else begin
            state   <= nxt_state;
            idx     <= nxt_idx;
            op_r    <= nxt_op;
            fpu_a   <= nxt_a;
            fpu_b   <= nxt_b;
            fpu_req <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_seq.sv
// Directed bench for sincos_seq with a behavioural FP32 unit acking 2 cycles after req.
module tb_sincos_seq;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] opx;
  logic        busy, done, err;
  logic [31:0] sine_result, cosine_result;
  logic        fpu_req, fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_ack;
  logic [31:0] fpu_result;

  logic        ack_m = 1'b0;
  logic [31:0] res_m = 32'd0;
  logic        spur;
  bit          ack_en;
  logic        prev_req = 1'b0;
  int          rises = 0;
  bit          log_op [64];
  logic [31:0] log_a  [64];
  logic [31:0] log_b  [64];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] es;
    logic [31:0] ec;
    int          tol_s;
    int          tol_c;
    bit          cos_abs;
  } vec_t;
  vec_t vt [4];

  assign fpu_ack    = ack_m | spur;
  assign fpu_result = spur ? 32'h7F7F_FFFF : res_m;

  sincos_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .opx(opx),
    .busy(busy), .done(done), .err(err),
    .sine_result(sine_result), .cosine_result(cosine_result),
    .fpu_req(fpu_req), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ack(fpu_ack), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    int          e;
    logic [30:0] v;
    logic [28:0] rem;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    v   = {e[7:0], d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && v[0])) v = v + 31'd1;
    return {d[63], v};
  endfunction

  function automatic bit near(input logic [31:0] a, input logic [31:0] e, input int tol);
    int da, de;
    if (a[31] != e[31]) return 1'b0;
    da = int'(a[30:0]);
    de = int'(e[30:0]);
    return ((da > de) ? da - de : de - da) <= tol;
  endfunction

  function automatic logic [5:0] lix(input int b, input int k);
    return 6'(b + k - 1);
  endfunction

  // FPU model: acks one cycle after it first sees a request.
  always @(posedge clk) begin
    ack_m <= 1'b0;
    if (fpu_req && !prev_req) begin
      log_op[rises[5:0]] <= fpu_op;
      log_a[rises[5:0]]  <= fpu_a;
      log_b[rises[5:0]]  <= fpu_b;
      rises <= rises + 1;
    end
    prev_req <= fpu_req;
    if (ack_en && fpu_req && !ack_m) begin
      ack_m <= 1'b1;
      res_m <= fpu_op ? r2fp(fp2r(fpu_a) + fp2r(fpu_b))
                      : r2fp(fp2r(fpu_a) * fp2r(fpu_b));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_ok(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected~%h", nm, act, exp);
    end
  endtask

  task automatic run_eval(input logic [31:0] x, input bit inj,
                          output int dcyc, output int nops, output int base);
    int n;
    bit did_start, did_spur;
    did_start = 1'b0;
    did_spur  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    opx   = x;
    @(posedge clk); #1;
    base  = rises;
    start = 1'b0;
    opx   = 32'h4049_0FDB;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    chk("req_cycle1", {31'd0, fpu_req}, 32'd1);
    n = 1;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      spur  = 1'b0;
      if (inj && !did_start && (rises - base) == 10) begin
        start = 1'b1;
        opx   = 32'h3FC9_0FDB;
        did_start = 1'b1;
      end
      if (inj && !did_spur && !fpu_req && (rises - base) == 5) begin
        spur = 1'b1;
        did_spur = 1'b1;
      end
    end
    start = 1'b0;
    spur  = 1'b0;
    dcyc  = done ? n : -1;
    nops  = rises - base;
  endtask

  initial begin
    int          dcyc, nops, base, n, hi;
    logic [31:0] x2e;
    n_rst  = 1'b0;
    start  = 1'b0;
    opx    = 32'd0;
    spur   = 1'b0;
    ack_en = 1'b1;
    vt[0] = '{32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 0, 0, 1'b0};
    vt[1] = '{32'h3FC9_0FDB, 32'h3F80_0000, 32'h0000_0000, 2, 0, 1'b1};
    vt[2] = '{32'h3F49_0FDB, 32'h3F35_04F3, 32'h3F35_04F3, 2, 2, 1'b0};
    vt[3] = '{32'hBF49_0FDB, 32'hBF35_04F3, 32'h3F35_04F3, 2, 2, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req", {31'd0, fpu_req}, 32'd0);
    chk("rst_sin", sine_result, 32'd0);
    chk("rst_cos", cosine_result, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_eval(vt[i].x, 1'b0, dcyc, nops, base);
      chk($sformatf("r%0d_done_cycle", i), 32'(dcyc), 32'd73);
      chk($sformatf("r%0d_ops", i), 32'(nops), 32'd24);
      chk($sformatf("r%0d_err", i), {31'd0, err}, 32'd0);
      chk($sformatf("r%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      chk_ok($sformatf("r%0d_sin", i), near(sine_result, vt[i].es, vt[i].tol_s),
             sine_result, vt[i].es);
      if (vt[i].cos_abs)
        chk_ok($sformatf("r%0d_cos_abs", i),
               fp2r(cosine_result) < 1.0e-6 && fp2r(cosine_result) > -1.0e-6,
               cosine_result, vt[i].ec);
      else
        chk_ok($sformatf("r%0d_cos", i), near(cosine_result, vt[i].ec, vt[i].tol_c),
               cosine_result, vt[i].ec);
      x2e = r2fp(fp2r(vt[i].x) * fp2r(vt[i].x));
      chk($sformatf("r%0d_op1_kind", i), {31'd0, log_op[lix(base, 1)]}, 32'd0);
      chk($sformatf("r%0d_op1_a", i), log_a[lix(base, 1)], vt[i].x);
      chk($sformatf("r%0d_op1_b", i), log_b[lix(base, 1)], vt[i].x);
      chk($sformatf("r%0d_op2_a", i), log_a[lix(base, 2)], 32'hB2D7_322B);
      chk($sformatf("r%0d_op2_b", i), log_b[lix(base, 2)], x2e);
      chk($sformatf("r%0d_op3_kind", i), {31'd0, log_op[lix(base, 3)]}, 32'd1);
      chk($sformatf("r%0d_op3_b", i), log_b[lix(base, 3)], 32'h3638_EF1D);
      chk($sformatf("r%0d_op12_b", i), log_b[lix(base, 12)], vt[i].x);
      chk($sformatf("r%0d_op13_a", i), log_a[lix(base, 13)], 32'h310F_76C7);
      chk($sformatf("r%0d_op24_b", i), log_b[lix(base, 24)], 32'h3F80_0000);
      @(posedge clk); #1;
      chk($sformatf("r%0d_done_drop", i), {31'd0, done}, 32'd0);
      chk($sformatf("r%0d_busy_after", i), {31'd0, busy}, 32'd0);
      chk_ok($sformatf("r%0d_sin_held", i), near(sine_result, vt[i].es, vt[i].tol_s),
             sine_result, vt[i].es);
    end

    // FPU that never answers
    ack_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    opx   = 32'h3F80_0000;
    @(posedge clk); #1;
    start = 1'b0;
    hi = 0;
    while (fpu_req && hi < 400) begin
      hi++;
      @(posedge clk); #1;
    end
    chk("to_req_cycles", 32'(hi), 32'(TO));
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_sin", sine_result, 32'h7FC0_0000);
    chk("to_cos", cosine_result, 32'h7FC0_0000);
    chk("to_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("to_busy_next", {31'd0, busy}, 32'd0);
    chk("to_done_next", {31'd0, done}, 32'd0);
    ack_en = 1'b1;

    // Restart and spurious ack during the run must not disturb it
    run_eval(32'h0000_0000, 1'b1, dcyc, nops, base);
    chk("inj_done_cycle", 32'(dcyc), 32'd73);
    chk("inj_ops", 32'(nops), 32'd24);
    chk("inj_sin", sine_result, 32'h0000_0000);
    chk("inj_cos", cosine_result, 32'h3F80_0000);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of op 12
    @(negedge clk);
    start = 1'b1;
    opx   = 32'h3F49_0FDB;
    @(posedge clk); #1;
    start = 1'b0;
    base  = rises;
    n = 0;
    while (!((rises - base) == 12 && fpu_req) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk_ok("mid_reach_op12", (rises - base) == 12 && fpu_req, 32'(rises - base), 32'd12);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, fpu_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done_err", {30'd0, done, err}, 32'd0);
    chk("arst_op", {31'd0, fpu_op}, 32'd0);
    chk("arst_a", fpu_a, 32'd0);
    chk("arst_b", fpu_b, 32'd0);
    chk("arst_sin", sine_result, 32'd0);
    chk("arst_cos", cosine_result, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    spur  = 1'b1;
    @(negedge clk);
    spur  = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_req", {31'd0, fpu_req}, 32'd0);
    run_eval(32'h0000_0000, 1'b0, dcyc, nops, base);
    chk("post_rst_done_cycle", 32'(dcyc), 32'd73);
    chk("post_rst_ops", 32'(nops), 32'd24);
    chk("post_rst_sin", sine_result, 32'h0000_0000);
    chk("post_rst_cos", cosine_result, 32'h3F80_0000);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sincos_seq.md
Name: sincos_seq

Overview:
Controller that evaluates sin(x) and cos(x) in IEEE-754 single precision. It sequences one shared external FP unit through Horner-form Taylor polynomials, one multiply or add operation at a time. The block sits between the host (start/done handshake) and the FP datapath (req/ack handshake). The input is already range-reduced to [-pi, pi]; range reduction is out of scope.

Parameters:
TIMEOUT, 255, max cycles fpu_req may stay high without fpu_ack before the block aborts (1..65535)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  start request, sampled only in IDLE
opx  in  32  operand x (FP32), captured when start is accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when results are valid
err  out  1  valid with done; 1 = FPU timeout
sine_result  out  32  sin(x), held until the next done
cosine_result  out  32  cos(x), held until the next done
fpu_req  out  1  operation request
fpu_op  out  1  0 = multiply, 1 = add
fpu_a  out  32  operand A
fpu_b  out  32  operand B
fpu_ack  in  1  one-cycle pulse, fpu_result valid
fpu_result  in  32  FP32 result

Behaviour:
- Reset (asynchronous, n_rst=0) forces all outputs to 0, the FSM to IDLE, and clears internal registers. The same applies on reset mid-operation: fpu_req drops immediately and a late fpu_ack after reset is ignored.
- FSM states: IDLE -> SQ -> SIN_MUL <-> SIN_ADD -> SIN_FIN -> COS_MUL <-> COS_ADD -> FIN -> IDLE. ABORT is reachable from any op state.
- SQ: x2 = x*x.
- Sine: p = S[5]. For k = 4 down to 0: p = p*x2 (SIN_MUL), then p = p + S[k] (SIN_ADD). SIN_FIN: sin = p*x.
- Cosine: q = C[6]. For k = 5 down to 0: q = q*x2, then q = q + C[k].
- The polynomial index counter is a 3-bit down-counter, reloaded at SIN_MUL entry (4) and COS_MUL entry (5).
- Total is exactly 24 FPU operations per evaluation.
- FPU handshake:
  - fpu_req, fpu_op, fpu_a and fpu_b are stable while fpu_req=1.
  - fpu_req drops in the cycle after fpu_ack.
  - The next request is issued one cycle later, so there is always exactly one idle cycle between ops.
  - One operation is outstanding at most. fpu_ack while fpu_req=0 is ignored.
- Latency: start is accepted at edge 0 and the first fpu_req is high in cycle 1. With the FPU acking L cycles after req rises (L>=1), each op costs L+1 cycles. done pulses in cycle 24*(L+1)+1.
- FIN: register sine/cosine results, pulse done, set err=0, busy=0 in the same cycle, then return to IDLE.
- Timeout:
  - A 16-bit counter increments each cycle fpu_req=1 and clears on fpu_ack.
  - When it reaches TIMEOUT, the block enters ABORT: fpu_req=0, both results = 0x7FC00000, done=1, err=1, then IDLE.
- start while busy is ignored (no queueing). start in the same cycle as done/FIN is also ignored; it is accepted only from IDLE.
- opx is captured on start acceptance; later changes to opx have no effect.
- No special-casing of zero, inf or NaN. The FPU result propagates as-is.

Decomposition:
- sincos_pkg holds:
  - FP_ONE = 32'h3F800000 and FP_QNAN = 32'h7FC00000.
  - S[0..5] = 1, -1/6, 1/120, -1/5040, 1/362880, -1/39916800 (FP32 constants).
  - C[0..6] = 1, -1/2, 1/24, -1/720, 1/40320, -1/3628800, 1/479001600 (signed; C[1] = 32'hBF000000).
  - The FSM state enum and the fpu_op enum (FPU_MUL, FPU_ADD).
- No sub-module; the FSM, index counter and timeout counter live in one module.

Test Plan:
- Bench FPU model (exact $shortreal math, L=2), opx=0x00000000: sine_result=0x00000000, cosine_result=0x3F800000, err=0, done in cycle 73, exactly 24 fpu_req rising edges.
- opx=0x3FC90FDB (pi/2): sine_result within 2 ulp of 0x3F800000, |cos| < 1e-6, op sequence starts MUL(x,x), MUL(S5,x2), ADD(·,S4).
- opx=0x3F490FDB (pi/4): sin and cos both within 2 ulp of 0x3F3504F3.
- FPU never acks, TIMEOUT=255: fpu_req high for 255 cycles, then 0; done=1 and err=1 with both results 0x7FC00000; busy=0 next cycle.
- start pulsed again at op 10 with a different opx: ignored, and results match the first opx. Spurious fpu_ack with fpu_req=0: no state change.
- n_rst asserted at op 12 while fpu_req=1: all outputs 0 asynchronously. After release, a new start completes normally with done in cycle 73.
